upsample2d_nn2x: RTL and testbench

- Streaming 2x nearest-neighbour upsampler, the inverse counterpart of the 2x2 stride-2 maxpool stage on the YOLO-style feature-map path.
- Accepts a raster-scan IN_SIZE x IN_SIZE frame, one DATA_WIDTH word per handshake.
- Emits a 2*IN_SIZE x 2*IN_SIZE frame: each input pixel is duplicated horizontally and each row is replayed once from an internal line buffer.
- Valid/ready on both sides, because output rate is 4x input rate.

---
 rtl/upsample2d_nn2x.sv | 103 ++++++++++
 tb/tb_upsample2d_nn2x.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/upsample2d_nn2x.sv
// rtl/upsample2d_nn2x.sv - streaming 2x nearest-neighbour upsampler (optional UPSAMPLE_LAST_EN adds last_out)
module upsample2d_nn2x #(
    parameter int DATA_WIDTH = 32,
    parameter int IN_SIZE    = 208
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  ready_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic                  ready_out
`ifdef UPSAMPLE_LAST_EN
    ,
    output logic                  last_out
`endif
);

    localparam int CW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(IN_SIZE - 1);

    typedef enum logic {PASS_A, PASS_B} state_t;

    state_t                state;
    logic [CW-1:0]         col;
    logic [CW-1:0]         row;
    logic                  dup;
    logic [DATA_WIDTH-1:0] linebuf [IN_SIZE];

    logic slot_free;
    logic in_xfer;

    assign slot_free = !valid_out || ready_out;
    assign ready_in  = !Rst && (state == PASS_A) && !dup && slot_free;
    assign in_xfer   = valid_in && ready_in;

    // Line buffer is never cleared; a row is always written before it is replayed.
    always_ff @(posedge Clk) begin
        if (in_xfer)
            linebuf[col] <= data_in;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= PASS_A;
            col       <= '0;
            row       <= '0;
            dup       <= 1'b0;
            data_out  <= '0;
            valid_out <= 1'b0;
`ifdef UPSAMPLE_LAST_EN
            last_out  <= 1'b0;
`endif
        end else if (slot_free) begin
            case (state)
                PASS_A: begin
                    if (!dup) begin
                        if (valid_in) begin
                            data_out  <= data_in;
                            valid_out <= 1'b1;
                            dup       <= 1'b1;
                        end else begin
                            valid_out <= 1'b0;
                        end
`ifdef UPSAMPLE_LAST_EN
                        last_out <= 1'b0;
`endif
                    end else begin
                        // Horizontal copy: data_out already holds this pixel.
                        valid_out <= 1'b1;
                        dup       <= 1'b0;
                        if (col == LAST_IDX) begin
                            col   <= '0;
                            state <= PASS_B;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                PASS_B: begin
                    data_out  <= linebuf[col];
                    valid_out <= 1'b1;
                    dup       <= ~dup;
`ifdef UPSAMPLE_LAST_EN
                    last_out  <= dup && (col == LAST_IDX) && (row == LAST_IDX);
`endif
                    if (dup) begin
                        if (col == LAST_IDX) begin
                            col   <= '0;
                            state <= PASS_A;
                            row   <= (row == LAST_IDX) ? '0 : row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                default: state <= PASS_A;
            endcase
        end
    end

endmodule

// File: tb/tb_upsample2d_nn2x.sv
// tb/tb_upsample2d_nn2x.sv - directed self-checking bench for upsample2d_nn2x at IN_SIZE=2
module tb_upsample2d_nn2x;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] data_in;
    logic        valid_in;
    logic        ready_in;
    logic [31:0] data_out;
    logic        valid_out;
    logic        ready_out;
`ifdef UPSAMPLE_LAST_EN
    logic        last_out;
`endif

    upsample2d_nn2x #(.DATA_WIDTH(32), .IN_SIZE(2)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_out (ready_out)
`ifdef UPSAMPLE_LAST_EN
        ,
        .last_out  (last_out)
`endif
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] in_vec [$];
    logic [31:0] out_q  [$];
    logic [31:0] exp_q  [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected 4x4 output of one 2x2 input frame a b / c d.
    task automatic push_frame(input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] c, input logic [31:0] d);
        logic [31:0] f [16];
        f = '{a, a, b, b, a, a, b, b, c, c, d, d, c, c, d, d};
        for (int i = 0; i < 16; i++) exp_q.push_back(f[i]);
    endtask

    task automatic compare_seq(input string name);
        check({name, "_count"}, out_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s[%0d]", name, i), (i < out_q.size()) ? out_q[i] : 32'hdead_beef, exp_q[i]);
    endtask

    // Drives in_vec with 'gap' idle cycles after each accepted word, optional 1,0,0,1 backpressure,
    // and collects n_out output transfers.
    task automatic run(input int gap, input bit bp, input int n_out,
                       output int idle, output int ready_hi, output int lat);
        int          in_idx   = 0;
        int          gap_cnt  = 0;
        int          cyc      = 0;
        int          first_in = -1;
        int          first_out = -1;
        bit          stall    = 0;
        logic [31:0] hold     = '0;
        idle = 0;
        ready_hi = 0;
        out_q.delete();
        while (out_q.size() < n_out && cyc < 2000) begin
            @(negedge Clk);
            ready_out = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            valid_in  = (in_idx < in_vec.size()) && (gap_cnt == 0);
            data_in   = valid_in ? in_vec[in_idx] : 32'h0;
            #1;
            if (stall) begin
                check("hold_data", data_out, hold);
                check("hold_valid", {31'b0, valid_out}, 32'd1);
            end
            stall = valid_out && !ready_out;
            hold  = data_out;
            if (out_q.size() > 0 && !valid_out) idle++;
            if (ready_in && in_idx < in_vec.size()) ready_hi++;
            if (valid_out && first_out < 0) first_out = cyc;
            if (valid_out && ready_out) begin
`ifdef UPSAMPLE_LAST_EN
                check("last_pos", {31'b0, last_out}, {31'b0, (out_q.size() % 16) == 15});
`endif
                out_q.push_back(data_out);
            end
            if (valid_in && ready_in) begin
                if (first_in < 0) first_in = cyc;
                in_idx++;
                gap_cnt = gap;
            end else if (!valid_in && gap_cnt > 0) begin
                gap_cnt--;
            end
            cyc++;
        end
        check("timeout", out_q.size(), n_out);
        lat = first_out - first_in;
        valid_in = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idle, ready_hi, lat;
        Rst = 1'b1;
        valid_in = 1'b0;
        data_in = '0;
        ready_out = 1'b1;
        repeat (2) @(negedge Clk);
        #1;
        check("rst_valid", {31'b0, valid_out}, 32'd0);
        check("rst_data", data_out, 32'd0);
        check("rst_ready_in", {31'b0, ready_in}, 32'd0);
`ifdef UPSAMPLE_LAST_EN
        check("rst_last", {31'b0, last_out}, 32'd0);
`endif
        @(negedge Clk);
        Rst = 1'b0;

        // Frame order, full rate
        in_vec = '{32'h1, 32'h2, 32'h3, 32'h4};
        exp_q.delete();
        push_frame(32'h1, 32'h2, 32'h3, 32'h4);
        run(0, 1'b0, 16, idle, ready_hi, lat);
        compare_seq("order");
        check("order_latency", lat, 32'd1);
        check("order_ready_cycles", ready_hi, 32'd4);
        check("order_idle", idle, 32'd0);

        // Backpressure 1,0,0,1
        run(0, 1'b1, 16, idle, ready_hi, lat);
        compare_seq("bp");

        // Input bubbles of 3 cycles
        run(3, 1'b0, 16, idle, ready_hi, lat);
        compare_seq("bubble");
        check("bubble_idle", idle, 32'd4);

        // Reset after the 6th output transfer
        run(0, 1'b0, 6, idle, ready_hi, lat);
        @(negedge Clk);
        Rst = 1'b1;
        valid_in = 1'b0;
        #1;
        check("midrst_ready_in", {31'b0, ready_in}, 32'd0);
        @(negedge Clk);
        Rst = 1'b0;
        #1;
        check("midrst_valid", {31'b0, valid_out}, 32'd0);
        check("midrst_data", data_out, 32'd0);
        in_vec = '{32'hA, 32'hB, 32'hC, 32'hD};
        exp_q.delete();
        push_frame(32'hA, 32'hB, 32'hC, 32'hD);
        run(0, 1'b0, 16, idle, ready_hi, lat);
        compare_seq("afterrst");
        check("afterrst_latency", lat, 32'd1);

        // Two frames back to back
        in_vec = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8};
        exp_q.delete();
        push_frame(32'h1, 32'h2, 32'h3, 32'h4);
        push_frame(32'h5, 32'h6, 32'h7, 32'h8);
        run(0, 1'b0, 32, idle, ready_hi, lat);
        compare_seq("b2b");
        check("b2b_idle", idle, 32'd0);
        check("b2b_ready_cycles", ready_hi, 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
